alu_mul_seq: RTL
================

# alu_mul_seq

Multi-cycle sequencer that borrows the shared 16-bit combinational ALU to compute a 16×16 multiply (low 16 bits of the product) by shift-and-add. It sits beside the EX stage. While the sequencer runs, it asserts `alu_sel` so the ALU operand mux takes its inputs from this block and the pipeline stalls. It releases the ALU when finished.

## Interface
- `WIDTH`, 16: operand, product and ALU data width. Fixed at 16 for this datapath.

- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request strobe. Sampled only in IDLE.
- `mcand` in 16: multiplicand, latched on accepted `start`.
- `mplier` in 16: multiplier, latched on accepted `start`.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse in the DONE state.
- `product` out 16: result register, held until the next accepted `start` completes.
- `zero` out 1: `product == 0`, registered together with `product`.
- `alu_sel` out 1: high in ADD and SHIFT; the top level's ALU operand mux selects this block.
- `alu_cs` out 4: ALU function select.
- `alu_src0` out 16, `alu_src1` out 16: ALU operands.
- `alu_shamt` out 4: ALU shift amount.
- `alu_cmplmt` out 1: ALU complement control; always 0.
- `alu_dst` in 16: ALU result. Combinational and valid in the same cycle.

## Operation
- State encoding: IDLE, ADD, SHIFT, DONE. Internal registers: `acc` (16), `mc` (16), `mp` (16).
- **IDLE:** ALU outputs are all 0 and `alu_sel`=0. On `start`=1:
  - `acc`←0, `mc`←`mcand`, `mp`←`mplier`.
  - Next state is ADD if `mplier` ≠ 0, else DONE.
- **ADD:**
  - Drive `alu_cs`=4'b1000 (plain unsaturated add; the ALU's add codes 0000/0001 saturate and must not be used).
  - Drive `alu_src0`=`acc`, `alu_src1` = `mp[0]` ? `mc` : 0, `alu_shamt`=0.
  - `acc`←`alu_dst`. Next state is SHIFT.
- **SHIFT:**
  - Drive `alu_cs`=4'b0101 (SLL), `alu_src0`=`mc`, `alu_src1`=0, `alu_shamt`=1.
  - `mc`←`alu_dst`, `mp`←`mp`>>1 (logical, internal).
  - Next state is DONE if (`mp`>>1)==0, else ADD.
- **DONE:**
  - `done`=1, `product`←`acc`, `zero`←(`acc`==0).
  - Next state is IDLE.
- Arithmetic:
  - All sums are taken mod 2^16 and carries are discarded.
  - The low 16 bits are identical for signed and unsigned operands, so no sign handling is needed.
- Iteration count n = index of the highest set bit of `mplier` + 1 (range 1..16). An early exit skips the trailing zero bits.
- `start` while busy is ignored; no queueing.
- `product`/`zero` change only on the DONE entry edge; they are stable at all other times.

## Timing
- Reset (async, immediate) sets:
  - state to IDLE;
  - `busy`, `done`, `alu_sel`, `alu_cs`, `alu_src0`, `alu_src1`, `alu_shamt`, `alu_cmplmt`, `product` to 0;
  - `zero` to 1;
  - `acc`, `mc`, `mp` to 0.
- Cycle numbering: cycle k begins k edges after the edge that samples `start`=1.
- `busy`=1 from cycle 1 through the DONE cycle inclusive.
- `alu_sel`=1 for exactly 2n cycles: cycles 1..2n.
- `done`=1 in cycle 2n+1, and `product` is valid from cycle 2n+1 onward. With `mplier`=0, `done` is in cycle 1 and `alu_sel` never rises.
- `start` may be reasserted in the cycle after DONE (IDLE); back-to-back throughput is therefore 2n+2 cycles.
- ALU outputs are Moore functions of state and registers. No combinational path exists from `alu_dst` to any output.
- Reset asserted mid-operation aborts immediately:
  - no `done` pulse;
  - `alu_sel` drops asynchronously;
  - the stalled pipeline must tolerate the abort.

## Test plan
- `mcand`=0x0003, `mplier`=0x0005 → n=3, `alu_sel` cycles 1–6, `done` in cycle 7, `product`=0x000F, `zero`=0.
- `mcand`=0x1234, `mplier`=0x0000 → `done` in cycle 1, `product`=0x0000, `zero`=1, `alu_sel` never 1.
- `mcand`=0x0003, `mplier`=0xFFFF (3 × −1) → n=16, `done` in cycle 33, `product`=0xFFFD.
- Non-saturating add check: `mcand`=0x3000, `mplier`=0x0007.
  - Intermediate `acc` values are 0x3000, 0x9000, 0x5000.
  - `product`=0x5000 with `done` in cycle 7.
  - A saturating add would yield 0x7FFF; check `alu_cs`=1000 in ADD and 0101 with `shamt`=1 in SHIFT.
- `mcand`=0x0100, `mplier`=0x0100 → n=9, `done` in cycle 19, `product`=0x0000 (wrap), `zero`=1.
- Aborts and ignored requests:
  - Pulse `start` with new operands in cycles 2–5 of a running job → ignored, and the result matches the first job.
  - Assert `rst` in cycle 4 → `busy`, `alu_sel`, `product`=0 immediately with no `done` pulse.
  - A fresh `start` after reset completes normally.

Source files
------------

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Brief    : Shift-and-add 16x16 multiplier (low 16 bits) that borrows the
//            shared combinational ALU, one ADD + one SHIFT cycle per bit.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0] mplier_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o,
    output logic             zero_o,
    output logic             alu_sel_o,
    output logic [3:0]       alu_cs_o,
    output logic [WIDTH-1:0] alu_src0_o,
    output logic [WIDTH-1:0] alu_src1_o,
    output logic [3:0]       alu_shamt_o,
    output logic             alu_cmplmt_o,
    input  logic [WIDTH-1:0] alu_dst_i
);

    // Plain wrapping add; the 0000/0001 add codes saturate and would corrupt acc.
    localparam logic [3:0] c_ALU_ADD = 4'b1000;
    localparam logic [3:0] c_ALU_SLL = 4'b0101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mc_q, mc_d;
    logic [WIDTH-1:0] mp_q, mp_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             zero_q, zero_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mc_q      <= '0;
            mp_q      <= '0;
            product_q <= '0;
            zero_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            product_q <= product_d;
            zero_q    <= zero_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mc_d         = mc_q;
        mp_d         = mp_q;
        product_d    = product_q;
        zero_d       = zero_q;
        alu_sel_o    = 1'b0;
        alu_cs_o     = 4'b0000;
        alu_src0_o   = '0;
        alu_src1_o   = '0;
        alu_shamt_o  = 4'd0;
        alu_cmplmt_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d = '0;
                    mc_d  = mcand_i;
                    mp_d  = mplier_i;
                    if (mplier_i != '0) begin
                        state_d = S_ADD;
                    end else begin
                        // Result register is loaded on the edge entering DONE.
                        state_d   = S_DONE;
                        product_d = '0;
                        zero_d    = 1'b1;
                    end
                end
            end
            S_ADD: begin
                alu_sel_o  = 1'b1;
                alu_cs_o   = c_ALU_ADD;
                alu_src0_o = acc_q;
                alu_src1_o = mp_q[0] ? mc_q : '0;
                acc_d      = alu_dst_i;
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                alu_sel_o   = 1'b1;
                alu_cs_o    = c_ALU_SLL;
                alu_src0_o  = mc_q;
                alu_shamt_o = 4'd1;
                mc_d        = alu_dst_i;
                mp_d        = mp_q >> 1;
                if ((mp_q >> 1) == '0) begin
                    state_d   = S_DONE;
                    product_d = acc_q;
                    zero_d    = (acc_q == '0);
                end else begin
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign product_o = product_q;
    assign zero_o    = zero_q;

endmodule
`default_nettype wire
